// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V opcode constants and fetch-stage types
package riscv_pkg;

  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry {pc, instr} FIFO with push, pop, flush and count
module fetch_queue
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_pop;

  assign do_pop = pop && (count != 2'd0);
  assign head   = mem[rd_ptr];

  // Storage needs no reset: the head is only looked at while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC owner, single-outstanding imem fetch, 2-entry decode queue
// Optional IF_MISALIGN_CHECK_EN: misaligned redirect sets sticky misalign and parks fetch.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        misalign
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  req_pc;
  logic         mis_q;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_data;
  logic         accept;
  logic         push;
  logic         pop;
  logic [31:0]  target;
  logic         bad_target;

`ifdef IF_MISALIGN_CHECK_EN
  assign target     = redirect_pc;
  assign bad_target = (redirect_pc[1:0] != 2'b00);
`else
  assign target     = redirect_pc & ~32'h3;
  assign bad_target = 1'b0;
`endif

  // Requests only issue with room in the queue, so a push can never overflow.
  assign imem_req_valid = (state == REQ) && (count < FULL);
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign push           = (state == WAIT) && imem_rsp_valid && !redirect_valid;
  assign pop            = dec_valid && dec_ready && !redirect_valid;
  assign push_data      = '{pc: req_pc, instr: imem_rsp_data};

  fetch_queue u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data (push_data),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      mis_q  <= 1'b0;
    end else if (redirect_valid) begin
      pc <= target;
      if (bad_target) begin
        mis_q <= 1'b1;
        state <= IDLE;
      end else begin
        // A redirect racing the response consumes it; otherwise it must be drained in DROP.
        case (state)
          IDLE:       state <= mis_q ? IDLE : REQ;
          REQ:        state <= accept ? DROP : REQ;
          WAIT, DROP: state <= imem_rsp_valid ? REQ : DROP;
          default:    state <= IDLE;
        endcase
      end
    end else begin
      case (state)
        IDLE: begin
          if (!mis_q) begin
            state <= REQ;
          end
        end
        REQ: begin
          if (accept) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= WAIT;
          end
        end
        WAIT, DROP: begin
          if (imem_rsp_valid) begin
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dec_valid = (count != 2'd0);
  assign dec_instr = dec_valid ? head.instr : NOP_INSTR;
  assign dec_pc    = dec_valid ? head.pc : 32'h0;
  assign opcode    = dec_instr[6:0];
  assign funct3    = dec_instr[14:12];
  assign funct7    = dec_instr[31:25];
  assign misalign  = mis_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed + randomized bench for instr_fetch with a queue-based reference model
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        misalign;

  int errors = 0;
  int checks = 0;

  instr_fetch #(.RESET_PC(32'h100), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7),
    .misalign       (misalign)
  );

  always #5 clk = ~clk;

  // Reference model: next fetch PC, one outstanding request, expected decode queue.
  logic [31:0] m_pc      = 32'h100;
  logic [31:0] m_req_pc  = 32'h100;
  bit          m_started = 1'b0;
  bit          m_busy    = 1'b0;
  bit          m_stale   = 1'b0;
  bit          m_mis     = 1'b0;
  logic [63:0] m_q[$];

  // Memory: answers each accepted request after 1 + extra cycles.
  bit          rand_mode   = 1'b0;
  int          dir_extra   = 0;
  bit          mem_pending = 1'b0;
  int          mem_cnt     = 0;
  logic [31:0] mem_data    = 32'h0;

  function automatic logic [31:0] dir_word(input logic [31:0] addr);
    return 32'h0050_0093 ^ ((addr - 32'h100) << 7);
  endfunction

  function automatic bit exp_req_valid();
    return m_started && !m_mis && !m_busy && (m_q.size() < 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    bit          acc;
    bit          pop;
    logic [31:0] tgt;
    acc = rst_n && exp_req_valid() && imem_req_ready;
    if (imem_rsp_valid) mem_pending = 1'b0;
    else if (mem_pending && mem_cnt > 0) mem_cnt--;
    if (acc) begin
      mem_pending = 1'b1;
      mem_cnt     = rand_mode ? int'($urandom_range(0, 2)) : dir_extra;
      mem_data    = rand_mode ? $urandom : dir_word(m_pc);
    end
    if (!rst_n) begin
      m_pc = 32'h100; m_req_pc = 32'h100;
      m_started = 0; m_busy = 0; m_stale = 0; m_mis = 0;
      m_q.delete();
    end else if (redirect_valid) begin
      tgt = redirect_pc;
`ifndef IF_MISALIGN_CHECK_EN
      tgt[1:0] = 2'b00;
`endif
      m_q.delete();
      m_pc = tgt;
      if (tgt[1:0] != 2'b00) begin
        m_mis  = 1'b1;
        m_busy = 1'b0;
      end else if (!m_mis) begin
        if (m_busy) begin
          if (imem_rsp_valid) m_busy = 1'b0;
          else m_stale = 1'b1;
        end else if (acc) begin
          m_busy = 1'b1; m_stale = 1'b1;
        end
        m_started = 1'b1;
      end
    end else if (m_mis) begin
      m_busy = 1'b0;
    end else if (!m_started) begin
      m_started = 1'b1;
    end else begin
      pop = (m_q.size() > 0) && dec_ready;
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        m_busy = 1'b1; m_stale = 1'b0; m_req_pc = m_pc; m_pc = m_pc + 32'd4;
      end else if (m_busy && imem_rsp_valid) begin
        if (!m_stale) m_q.push_back({m_req_pc, imem_rsp_data});
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [63:0] h;
    logic [31:0] ei;
    h  = (m_q.size() > 0) ? m_q[0] : {32'h0, 32'h0000_0013};
    ei = h[31:0];
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req_valid()));
    chk("req_addr", imem_req_addr, m_pc);
    chk("dec_valid", 32'(dec_valid), 32'(m_q.size() > 0));
    chk("dec_pc", dec_pc, h[63:32]);
    chk("dec_instr", dec_instr, ei);
    chk("opcode", 32'(opcode), 32'(ei[6:0]));
    chk("funct3", 32'(funct3), 32'(ei[14:12]));
    chk("funct7", 32'(funct7), 32'(ei[31:25]));
    chk("misalign", 32'(misalign), 32'(m_mis));
    imem_rsp_valid = mem_pending && (mem_cnt == 0);
    imem_rsp_data  = imem_rsp_valid ? mem_data : $urandom;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req_valid && n < 20) begin
      tick();
      n++;
    end
    if (!imem_req_valid) begin
      checks++; errors++;
      $display("FAIL wait_req: timeout, req_valid=%b required 1", imem_req_valid);
    end
  endtask

  task automatic wait_dec();
    int n = 0;
    while (!dec_valid && n < 20) begin
      tick();
      n++;
    end
    if (!dec_valid) begin
      checks++; errors++;
      $display("FAIL wait_dec: timeout, dec_valid=%b required 1", dec_valid);
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h100);
    chk("rst_dec_instr", dec_instr, 32'h0000_0013);
    chk("rst_opcode", 32'(opcode), 32'h13);
    rst_n = 1'b1;
    tick();
    chk("first_req_valid", 32'(imem_req_valid), 32'h1);
    chk("first_req_addr", imem_req_addr, 32'h100);
    tick();
    tick();
    chk("first_dec_valid", 32'(dec_valid), 32'h1);
    chk("first_dec_pc", dec_pc, 32'h100);
    chk("first_dec_instr", dec_instr, 32'h0050_0093);
    chk("first_opcode", 32'(opcode), 32'b0010011);

    // Backpressure: two buffered, fetch stalls; one pop frees exactly one request.
    repeat (5) tick();
    chk("bp_req_valid", 32'(imem_req_valid), 32'h0);
    chk("bp_dec_pc", dec_pc, 32'h100);
    dir_extra = 2;
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    chk("bp_req_addr", imem_req_addr, 32'h108);
    chk("bp_req_valid1", 32'(imem_req_valid), 32'h1);
    tick();
    chk("bp_wait_no_req", 32'(imem_req_valid), 32'h0);

    // Redirect while 0x108 is outstanding.
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    dir_extra = 0;
    chk("rw_flushed", 32'(dec_valid), 32'h0);
    wait_req();
    chk("rw_req_addr", imem_req_addr, 32'h200);
    wait_dec();
    chk("rw_dec_pc", dec_pc, 32'h200);

    // Redirect coinciding with the response.
    wait_req();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    chk("rr_req_addr", imem_req_addr, 32'h40);
    chk("rr_not_pushed", 32'(dec_valid), 32'h0);

    // PC wrap.
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    dec_ready = 1'b1;
    tick();
    chk("wrap_next_addr", imem_req_addr, 32'h0);

    // Misaligned redirect.
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h202;
    tick();
    redirect_valid = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    chk("mis_flag", 32'(misalign), 32'h1);
    repeat (5) tick();
    chk("mis_no_req", 32'(imem_req_valid), 32'h0);
    chk("mis_dec_valid", 32'(dec_valid), 32'h0);
`else
    wait_req();
    chk("mis_req_addr", imem_req_addr, 32'h200);
    chk("mis_flag", 32'(misalign), 32'h0);
`endif

    // Reset with a request in flight; the late response must be ignored.
    dir_extra = 2;
`ifndef IF_MISALIGN_CHECK_EN
    wait_req();
    tick();
`endif
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    tick();
    chk("mid_rst_dec_valid", 32'(dec_valid), 32'h0);
    chk("mid_rst_addr", imem_req_addr, 32'h100);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("late_rsp_ignored", 32'(dec_valid), 32'h0);
    dir_extra = 0;
    imem_req_ready = 1'b1;
    wait_req();
    chk("post_rst_addr", imem_req_addr, 32'h100);

    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      dec_ready      = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
`ifdef IF_MISALIGN_CHECK_EN
      redirect_pc[1:0] = 2'b00;
`endif
    end
    redirect_valid = 1'b0;
    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
